reg_bank_avalon_interface: RTL and testbench



---
 rtl/reg_bank_avalon_interface.sv | 133 +++++++++++++
 tb/tb_reg_bank_avalon_interface.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_avalon_interface.sv
// Avalon-MM slave register bank with byte-lane writes, read latency 1, per-register write strobes and a flat export bus.
// Optional shadow/commit mode for atomic export updates: define REGBANK_SHADOW_EN.
module reg_bank_avalon_interface #(
    parameter int unsigned       DATA_W    = 16,
    parameter int unsigned       NUM_REGS  = 4,
    parameter int unsigned       ADDR_W    = 3,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [ADDR_W-1:0]            address,
    input  logic                         chipselect,
    input  logic                         write,
    input  logic                         read,
    input  logic [DATA_W/8-1:0]          byteenable,
    input  logic [DATA_W-1:0]            writedata,
    output logic [DATA_W-1:0]            readdata,
    output logic [NUM_REGS-1:0]          wr_pulse,
    output logic [NUM_REGS*DATA_W-1:0]   Q_export
);

    localparam int unsigned NUM_BYTES = DATA_W / 8;

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
    logic [DATA_W-1:0]   rd_val_c;
    logic                wr_acc_c, rd_acc_c, in_range_c;

`ifdef REGBANK_SHADOW_EN
    logic [DATA_W-1:0]   live_q [NUM_REGS];
    logic [DATA_W-1:0]   live_d [NUM_REGS];
    logic                pending_q, pending_d;
`endif

    assign wr_acc_c   = chipselect & write;
    assign rd_acc_c   = chipselect & read;
    assign in_range_c = (address < ADDR_W'(NUM_REGS));

    // Read mux sees pre-write register state, so same-cycle read+write returns the old value.
    always_comb begin
        rd_val_c = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (address == ADDR_W'(i)) begin
                rd_val_c = regs_q[i];
            end
        end
`ifdef REGBANK_SHADOW_EN
        if (address == ADDR_W'(NUM_REGS)) begin
            rd_val_c = {{(DATA_W-1){1'b0}}, pending_q};
        end
`endif
    end

    // Next-state: byte-lane merge, strobes, readback capture and (shadow mode) commit.
    always_comb begin
        regs_d     = regs_q;
        wr_pulse_d = '0;
        rd_data_d  = rd_data_q;
`ifdef REGBANK_SHADOW_EN
        live_d     = live_q;
        pending_d  = pending_q;
`endif
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (wr_acc_c && (address == ADDR_W'(i))) begin
                for (int unsigned b = 0; b < NUM_BYTES; b++) begin
                    if (byteenable[b]) begin
                        regs_d[i][b*8 +: 8] = writedata[b*8 +: 8];
                    end
                end
                wr_pulse_d[i] = |byteenable;
            end
        end
`ifdef REGBANK_SHADOW_EN
        if (wr_acc_c && in_range_c && (|byteenable)) begin
            pending_d = 1'b1;
        end
        if (wr_acc_c && (address == ADDR_W'(NUM_REGS)) && byteenable[0] && writedata[0]) begin
            live_d    = regs_q;
            pending_d = 1'b0;
        end
`endif
        if (rd_acc_c) begin
            rd_data_d = in_range_c ? rd_val_c :
`ifdef REGBANK_SHADOW_EN
                        rd_val_c;
`else
                        '0;
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
            rd_data_q  <= '0;
            wr_pulse_q <= '0;
        end else begin
            regs_q     <= regs_d;
            rd_data_q  <= rd_data_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

`ifdef REGBANK_SHADOW_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                live_q[i] <= RESET_VAL;
            end
            pending_q <= 1'b0;
        end else begin
            live_q    <= live_d;
            pending_q <= pending_d;
        end
    end
`endif

    assign readdata = rd_data_q;
    assign wr_pulse = wr_pulse_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_export
`ifdef REGBANK_SHADOW_EN
        assign Q_export[g*DATA_W +: DATA_W] = live_q[g];
`else
        assign Q_export[g*DATA_W +: DATA_W] = regs_q[g];
`endif
    end

endmodule

// File: tb/tb_reg_bank_avalon_interface.sv
// Self-checking bench for reg_bank_avalon_interface: directed vector table, async-reset sequence, randomized traffic vs a reference model.
module tb_reg_bank_avalon_interface;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect, write, read;
    logic [1:0]  byteenable;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic [3:0]  wr_pulse;
    logic [63:0] Q_export;

    int checks = 0;
    int errors = 0;

    reg_bank_avalon_interface #(
        .DATA_W(16), .NUM_REGS(4), .ADDR_W(3), .RESET_VAL(16'h0000)
    ) dut (
        .clock(clock), .reset(reset), .address(address), .chipselect(chipselect),
        .write(write), .read(read), .byteenable(byteenable), .writedata(writedata),
        .readdata(readdata), .wr_pulse(wr_pulse), .Q_export(Q_export)
    );

    always #5 clock = ~clock;

    // Reference model: register contents as plain arrays, updated per accepted transaction.
    logic [15:0] m_reg  [4];
    logic [15:0] m_live [4];
    logic        m_pend;
    logic [15:0] m_rd;
    logic [3:0]  m_pulse;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_reg[i]  = 16'h0000;
            m_live[i] = 16'h0000;
        end
        m_pend  = 1'b0;
        m_rd    = 16'h0000;
        m_pulse = 4'h0;
    endfunction

    function automatic void model_apply(input logic cs, input logic wr, input logic rd,
                                        input logic [2:0] a, input logic [1:0] be,
                                        input logic [15:0] wd);
        int ai;
        ai = int'(a);
        if (cs && rd) begin
            if (ai < 4) m_rd = m_reg[ai];
`ifdef REGBANK_SHADOW_EN
            else if (ai == 4) m_rd = {15'h0, m_pend};
`endif
            else m_rd = 16'h0000;
        end
        m_pulse = 4'h0;
        if (cs && wr) begin
            if (ai < 4 && be != 2'b00) begin
                if (be[0]) m_reg[ai] = (m_reg[ai] & 16'hFF00) | (wd & 16'h00FF);
                if (be[1]) m_reg[ai] = (m_reg[ai] & 16'h00FF) | (wd & 16'hFF00);
                m_pulse[ai] = 1'b1;
                m_pend = 1'b1;
            end
`ifdef REGBANK_SHADOW_EN
            else if (ai == 4 && be[0] && wd[0]) begin
                for (int i = 0; i < 4; i++) m_live[i] = m_reg[i];
                m_pend = 1'b0;
            end
`endif
        end
    endfunction

    function automatic logic [63:0] model_export();
        logic [63:0] e;
        for (int i = 0; i < 4; i++) begin
`ifdef REGBANK_SHADOW_EN
            e[i*16 +: 16] = m_live[i];
`else
            e[i*16 +: 16] = m_reg[i];
`endif
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One bus cycle: drive at negedge, let the edge happen, update model, sample 1ns later.
    task automatic step(input logic cs, input logic wr, input logic rd, input logic [2:0] a,
                        input logic [1:0] be, input logic [15:0] wd);
        @(negedge clock);
        chipselect = cs; write = wr; read = rd; address = a; byteenable = be; writedata = wd;
        @(posedge clock);
        model_apply(cs, wr, rd, a, be, wd);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 3'd0, 2'b00, 16'h0000);
    endtask

    typedef struct packed {
        logic        cs, wr, rd;
        logic [2:0]  addr;
        logic [1:0]  be;
        logic [15:0] wd;
        logic [15:0] exp_rd;
        logic [3:0]  exp_pulse;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 3'd0, 2'b00, 16'h0000, 16'h0000, 4'b0000};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 3'd1, 2'b00, 16'h0000, 16'h0000, 4'b0000};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 3'd2, 2'b00, 16'h0000, 16'h0000, 4'b0000};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 3'd3, 2'b00, 16'h0000, 16'h0000, 4'b0000};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 3'd2, 2'b01, 16'hABCD, 16'h0000, 4'b0100};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 3'd2, 2'b00, 16'h0000, 16'h00CD, 4'b0000};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 3'd2, 2'b10, 16'h12FF, 16'h00CD, 4'b0100};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 3'd2, 2'b00, 16'h0000, 16'h12CD, 4'b0000};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 3'd1, 2'b11, 16'h0001, 16'h12CD, 4'b0010};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 3'd1, 2'b11, 16'h5555, 16'h0001, 4'b0010};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 3'd1, 2'b00, 16'h0000, 16'h5555, 4'b0000};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 3'd5, 2'b11, 16'hFFFF, 16'h5555, 4'b0000};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 3'd6, 2'b00, 16'h0000, 16'h0000, 4'b0000};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 3'd0, 2'b00, 16'hFFFF, 16'h0000, 4'b0000};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 3'd0, 2'b00, 16'h0000, 16'h0000, 4'b0000};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 3'd3, 2'b11, 16'h7777, 16'h0000, 4'b0000};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 3'd3, 2'b11, 16'hBEEF, 16'h0000, 4'b1000};
        vecs[17] = '{1'b1, 1'b1, 1'b0, 3'd3, 2'b11, 16'hCAFE, 16'h0000, 4'b1000};
        vecs[18] = '{1'b1, 1'b0, 1'b1, 3'd3, 2'b00, 16'h0000, 16'hCAFE, 4'b0000};
        vecs[19] = '{1'b0, 1'b0, 1'b1, 3'd2, 2'b00, 16'h0000, 16'hCAFE, 4'b0000};
    end

    initial begin
        reset = 1'b1;
        chipselect = 1'b0; write = 1'b0; read = 1'b0;
        address = 3'd0; byteenable = 2'b00; writedata = 16'h0000;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check("reset_readdata", 64'(readdata), 64'h0);
        check("reset_wr_pulse", 64'(wr_pulse), 64'h0);
        check("reset_q_export", Q_export, 64'h0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].cs, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].be, vecs[i].wd);
            check($sformatf("vec%0d_readdata", i), 64'(readdata), 64'(vecs[i].exp_rd));
            check($sformatf("vec%0d_wr_pulse", i), 64'(wr_pulse), 64'(vecs[i].exp_pulse));
            check($sformatf("vec%0d_q_export", i), Q_export, model_export());
        end
`ifndef REGBANK_SHADOW_EN
        check("q_export_reg2", 64'(Q_export[47:32]), 64'h12CD);
`endif

`ifdef REGBANK_SHADOW_EN
        // Shadow writes stay hidden until a commit to the control address.
        step(1'b1, 1'b1, 1'b0, 3'd0, 2'b11, 16'h1111);
        step(1'b1, 1'b1, 1'b0, 3'd3, 2'b11, 16'h2222);
        check("shadow_q_unchanged", Q_export, model_export());
        step(1'b1, 1'b0, 1'b1, 3'd4, 2'b00, 16'h0000);
        check("shadow_pending_set", 64'(readdata), 64'h0001);
        step(1'b1, 1'b1, 1'b0, 3'd4, 2'b01, 16'h0001);
        check("shadow_commit_q0", 64'(Q_export[15:0]), 64'h1111);
        check("shadow_commit_q3", 64'(Q_export[63:48]), 64'h2222);
        step(1'b1, 1'b0, 1'b1, 3'd4, 2'b00, 16'h0000);
        check("shadow_pending_clr", 64'(readdata), 64'h0000);
`endif

        // Async reset between the two halves of a split-lane write.
        step(1'b1, 1'b1, 1'b1, 3'd0, 2'b01, 16'h00AA);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_readdata", 64'(readdata), 64'h0);
        check("async_rst_wr_pulse", 64'(wr_pulse), 64'h0);
        check("async_rst_q_export", Q_export, 64'h0);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chipselect = 1'b0; write = 1'b0; read = 1'b0;
        step(1'b1, 1'b1, 1'b0, 3'd0, 2'b10, 16'h5500);
        step(1'b1, 1'b0, 1'b1, 3'd0, 2'b00, 16'h0000);
        check("after_rst_reg0", 64'(readdata), 64'h5500);
        check("after_rst_model_rd", 64'(readdata), 64'(m_rd));

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            logic cs, wr, rd;
            logic [2:0] a;
            logic [1:0] be;
            logic [15:0] wd;
            cs = ($urandom_range(0, 7) != 0);
            wr = $urandom_range(0, 1) == 1;
            rd = $urandom_range(0, 1) == 1;
            a  = 3'($urandom_range(0, 7));
            be = 2'($urandom_range(0, 3));
            wd = 16'($urandom);
            step(cs, wr, rd, a, be, wd);
            check($sformatf("rand%0d_readdata", n), 64'(readdata), 64'(m_rd));
            check($sformatf("rand%0d_wr_pulse", n), 64'(wr_pulse), 64'(m_pulse));
            check($sformatf("rand%0d_q_export", n), Q_export, model_export());
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
